// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode run-length capture front end.
// Run bytes carry the level of the completed run in the MSB and its saturated width below.
package barcode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_QUIET,
        ST_WAIT_BAR,
        ST_CAPTURE,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } state_t;

    localparam logic [11:0] HDR_LO_ADDR   = 12'd0;
    localparam logic [11:0] HDR_HI_ADDR   = 12'd1;
    localparam logic [11:0] RUN_BASE_ADDR = 12'd2;

    localparam logic [6:0] RUN_LEN_MAX = 7'd127;

    localparam int RUN_LVL_BIT = 7;
    localparam int RUN_LEN_MSB = 6;
    localparam int RUN_LEN_LSB = 0;

    function automatic logic [7:0] make_run_byte(input logic level, input logic [6:0] len);
        logic [7:0] b;
        b = 8'd0;
        b[RUN_LVL_BIT] = level;
        b[RUN_LEN_MSB:RUN_LEN_LSB] = len;
        return b;
    endfunction

endpackage

// File: rtl/barcode_sync_filter.sv
// Two-flop synchronizer followed by a persistence filter on the raw sensor line.
// o_edge is high in the last cycle of the old level, i.e. the cycle whose clock edge flips o_level.
module barcode_sync_filter #(
    parameter int FILTER = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_edge
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_accept;

    assign w_diff   = (r_sync != r_level);
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            if (w_accept) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_edge  = w_accept;

endmodule

// File: rtl/barcode_run_capture.sv
// Measures filtered dark/light run widths and streams them as bytes into on-chip memory,
// closing each capture with a two-byte run-count header at addresses 0/1.
module barcode_run_capture
    import barcode_pkg::*;
#(
    parameter int PRESCALE = 50,
    parameter int QUIET    = 100,
    parameter int FILTER   = 3,
    parameter int MAX_RUNS = 4094
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        sensor_in,
    input  logic        arm,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [11:0] run_count,
    output logic [11:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    output logic        mem_write,
    output logic [7:0]  mem_writedata
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int QW = $clog2(QUIET + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [QW-1:0] QUIET_Q  = QW'(QUIET);
    localparam logic [QW-1:0] QUIET_M1 = QW'(QUIET - 1);
    localparam logic [11:0]   LAST_RUN = 12'(MAX_RUNS - 1);

    logic          w_level;
    logic          w_edge;
    logic          w_tick;
    logic          w_quiet_hit;
    logic          w_arm_ok;
    logic [6:0]    w_run_len;

    logic [PW-1:0] r_pre;
    logic [6:0]    r_units;
    logic [QW-1:0] r_quiet;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_ovf;
    logic [11:0]   r_count;
    logic [11:0]   r_addr;
    logic [7:0]    r_data;
    logic          r_we;

    barcode_sync_filter #(.FILTER(FILTER)) u_filter (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_din   (sensor_in),
        .o_level (w_level),
        .o_edge  (w_edge)
    );

    // The current cycle still belongs to the run being measured, so its tick is folded in.
    assign w_tick      = (r_pre == PRE_LAST);
    assign w_run_len   = (r_units == RUN_LEN_MAX) ? RUN_LEN_MAX : r_units + 7'(w_tick);
    assign w_quiet_hit = (r_quiet == QUIET_Q) || (w_tick && (r_quiet == QUIET_M1));
    assign w_arm_ok    = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_pre   <= '0;
            r_units <= '0;
            r_quiet <= '0;
        end else if (w_edge || w_arm_ok) begin
            r_pre   <= '0;
            r_units <= '0;
            r_quiet <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick && (r_units != RUN_LEN_MAX))
                r_units <= r_units + 1'b1;
            if (w_tick && (r_quiet != QUIET_Q))
                r_quiet <= r_quiet + 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        r_state <= ST_WAIT_QUIET;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_count <= '0;
                    end
                end
                ST_WAIT_QUIET: begin
                    if (!w_edge && !w_level && w_quiet_hit)
                        r_state <= ST_WAIT_BAR;
                end
                ST_WAIT_BAR: begin
                    if (w_edge && !w_level)
                        r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // An edge coinciding with the quiet threshold still closes a stored run.
                    if (w_edge) begin
                        r_we    <= 1'b1;
                        r_addr  <= RUN_BASE_ADDR + r_count;
                        r_data  <= make_run_byte(w_level, w_run_len);
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_RUN) begin
                            r_ovf   <= 1'b1;
                            r_state <= ST_WR_LO;
                        end
                    end else if (!w_level && w_quiet_hit) begin
                        r_state <= ST_WR_LO;
                    end
                end
                ST_WR_LO: begin
                    r_we    <= 1'b1;
                    r_addr  <= HDR_LO_ADDR;
                    r_data  <= r_count[7:0];
                    r_state <= ST_WR_HI;
                end
                ST_WR_HI: begin
                    r_we    <= 1'b1;
                    r_addr  <= HDR_HI_ADDR;
                    r_data  <= {4'b0000, r_count[11:8]};
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow       = r_ovf;
    assign run_count      = r_count;
    assign mem_address    = r_addr;
    assign mem_writedata  = r_data;
    assign mem_chipselect = r_we;
    assign mem_clken      = r_we;
    assign mem_write      = r_we;

endmodule

// File: tb/tb_barcode_run_capture.sv
// Directed bench for barcode_run_capture with PRESCALE=4, QUIET=8, FILTER=2, MAX_RUNS=4.
// Memory writes are logged at the clock edge and compared against hand-derived byte lists.
module tb_barcode_run_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sensor;
    logic        arm;
    logic        busy, done, overflow;
    logic [11:0] run_count;
    logic [11:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [7:0]  mem_writedata;

    int checks = 0;
    int errors = 0;
    int strobe_bad = 0;

    logic [11:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    always #5 clk = ~clk;

    barcode_run_capture #(
        .PRESCALE(4), .QUIET(8), .FILTER(2), .MAX_RUNS(4)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .sensor_in      (sensor),
        .arm            (arm),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .run_count      (run_count),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata)
    );

    always @(posedge clk) begin
        if ((mem_write !== mem_chipselect) || (mem_write !== mem_clken))
            strobe_bad++;
        if (mem_write === 1'b1) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_writedata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic lvl, input int n);
        sensor = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [11:0] a, input logic [7:0] d);
        chk($sformatf("%s_addr%0d", tag, idx), 32'(wr_addr_q[idx]), 32'(a));
        chk($sformatf("%s_data%0d", tag, idx), 32'(wr_data_q[idx]), 32'(d));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_cnt"}, 32'(run_count), 32'd0);
        chk({tag, "_we"}, 32'(mem_write), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_writedata), 32'd0);
    endtask

    initial begin
        int base;
        rst_n  = 1'b0;
        sensor = 1'b0;
        arm    = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");
        repeat (200) @(negedge clk);
        chk("idle_nwr", 32'(wr_addr_q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // basic capture, with an ignored arm inside the light run
        base = wr_addr_q.size();
        arm_pulse();
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_cnt0", 32'(run_count), 32'd0);
        run(0, 40); run(1, 12); run(0, 10);
        arm_pulse();
        chk("armbusy_cnt", 32'(run_count), 32'd1);
        chk("armbusy_busy", 32'(busy), 32'd1);
        run(0, 9); run(1, 8); run(0, 40);
        wait_done("basic");
        chk("basic_nwr", 32'(wr_addr_q.size() - base), 32'd5);
        chk_wr("basic", base + 0, 12'd2, 8'h83);
        chk_wr("basic", base + 1, 12'd3, 8'h05);
        chk_wr("basic", base + 2, 12'd4, 8'h82);
        chk_wr("basic", base + 3, 12'd0, 8'h03);
        chk_wr("basic", base + 4, 12'd1, 8'h00);
        chk("basic_cnt", 32'(run_count), 32'd3);
        chk("basic_busy_end", 32'(busy), 32'd0);
        chk("basic_ovf", 32'(overflow), 32'd0);

        // glitch rejection, re-arm after done clears run_count
        base = wr_addr_q.size();
        arm_pulse();
        chk("rearm_cnt", 32'(run_count), 32'd0);
        chk("rearm_done", 32'(done), 32'd0);
        run(0, 40); run(1, 5); run(0, 1); run(1, 6); run(0, 16); run(1, 4); run(0, 40);
        wait_done("glitch");
        chk("glitch_nwr", 32'(wr_addr_q.size() - base), 32'd5);
        chk_wr("glitch", base + 0, 12'd2, 8'h83);
        chk_wr("glitch", base + 1, 12'd3, 8'h04);
        chk_wr("glitch", base + 2, 12'd4, 8'h81);
        chk_wr("glitch", base + 3, 12'd0, 8'h03);
        chk("glitch_cnt", 32'(run_count), 32'd3);

        // saturation, then a light run ending exactly on the quiet threshold
        base = wr_addr_q.size();
        arm_pulse();
        run(0, 40); run(1, 600); run(0, 32); run(1, 4); run(0, 40);
        wait_done("sat");
        chk("sat_nwr", 32'(wr_addr_q.size() - base), 32'd5);
        chk_wr("sat", base + 0, 12'd2, 8'hFF);
        chk_wr("sat", base + 1, 12'd3, 8'h08);
        chk_wr("sat", base + 2, 12'd4, 8'h81);
        chk_wr("sat", base + 3, 12'd0, 8'h03);
        chk_wr("sat", base + 4, 12'd1, 8'h00);

        // overflow at MAX_RUNS=4 with six short runs
        base = wr_addr_q.size();
        arm_pulse();
        run(0, 40);
        for (int i = 0; i < 3; i++) begin
            run(1, 4); run(0, 4);
        end
        run(0, 40);
        wait_done("ovf");
        repeat (20) @(negedge clk);
        chk("ovf_nwr", 32'(wr_addr_q.size() - base), 32'd6);
        chk_wr("ovf", base + 0, 12'd2, 8'h81);
        chk_wr("ovf", base + 1, 12'd3, 8'h01);
        chk_wr("ovf", base + 2, 12'd4, 8'h81);
        chk_wr("ovf", base + 3, 12'd5, 8'h01);
        chk_wr("ovf", base + 4, 12'd0, 8'h04);
        chk_wr("ovf", base + 5, 12'd1, 8'h00);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(run_count), 32'd4);

        // reset in the middle of a capture
        arm_pulse();
        chk("mid_ovf_clr", 32'(overflow), 32'd0);
        run(0, 40); run(1, 8); run(0, 8);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_cnt", 32'(run_count), 32'd1);
        base = wr_addr_q.size();
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        sensor = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        run(1, 10); run(0, 40); run(1, 6); run(0, 40);
        chk("midrst_nwr", 32'(wr_addr_q.size() - base), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);

        // fresh capture after reset
        base = wr_addr_q.size();
        arm_pulse();
        chk("post_busy", 32'(busy), 32'd1);
        chk("post_cnt0", 32'(run_count), 32'd0);
        run(0, 40); run(1, 8); run(0, 40);
        wait_done("post");
        chk("post_nwr", 32'(wr_addr_q.size() - base), 32'd3);
        chk_wr("post", base + 0, 12'd2, 8'h82);
        chk_wr("post", base + 1, 12'd0, 8'h01);
        chk_wr("post", base + 2, 12'd1, 8'h00);
        chk("post_cnt", 32'(run_count), 32'd1);

        chk("strobes", 32'(strobe_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barcode_run_capture.md
Name: barcode_run_capture

Overview:
Front-end stage that feeds the Nios barcode system. It samples the raw optical sensor line and measures alternating dark/light run widths. Each run is written as one byte into on-chip memory through the memory's second (s2) slave port. When capture ends, it writes a run-count header so the Nios software can decode the symbol from memory.

Parameters:
PRESCALE, 50, clock cycles per run-length unit (1 us at 50 MHz)
QUIET, 100, light run length in units that defines a quiet zone
FILTER, 3, consecutive stable cycles required to accept a level change
MAX_RUNS, 4094, run bytes storable (addresses 2..4095)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  synchronous, active-low reset
sensor_in  in  1  raw asynchronous sensor line, 1 = dark bar
arm  in  1  single-cycle pulse: start a capture
busy  out  1  high from accepted arm until header written
done  out  1  high after header written, until next arm or reset
overflow  out  1  capture stopped because MAX_RUNS was reached
run_count  out  12  runs stored in last or current capture
mem_address  out  12  drives onchip_memory2_1_s2_address
mem_chipselect  out  1  drives onchip_memory2_1_s2_chipselect
mem_clken  out  1  drives onchip_memory2_1_s2_clken
mem_write  out  1  drives onchip_memory2_1_s2_write
mem_writedata  out  8  drives onchip_memory2_1_s2_writedata

Behaviour:
- Reset: applied synchronously while reset_reset_n = 0; all outputs 0; state IDLE; counters 0. Reset mid-capture or mid-write aborts with no further writes, and memory contents are left undefined.
- Input path: 2-FF synchronizer, then a glitch filter. The filtered level changes only after the synchronized input differs from it for FILTER consecutive cycles. Edge latency is 2 + FILTER cycles. The filtered level resets to 0 (light).
- Prescaler and run counter:
  - Prescaler counts 0..PRESCALE-1 and emits a tick on wrap.
  - Unit counter increments per tick and saturates at 127 for the stored value.
  - A separate quiet counter saturates at QUIET.
  - Both the prescaler and the unit counter clear on every accepted filtered edge.
- Run byte: bit7 = level of the completed run; bits6:0 = min(units, 127).
- FSM:
  - IDLE: on arm, go to WAIT_QUIET. busy=1, done=0, overflow=0, run_count=0.
  - WAIT_QUIET: filtered level must be light for QUIET units. Any dark edge restarts the count. On reaching QUIET, go to WAIT_BAR.
  - WAIT_BAR: the first light->dark edge clears the counters and enters CAPTURE. No byte is written for the quiet zone.
  - CAPTURE: on each filtered edge, write the completed run byte at address 2+run_count in that same cycle, then increment run_count. Exit conditions:
    - A light run reaching QUIET units ends capture; the trailing light run is not stored. Go to WR_LO.
    - When run_count reaches MAX_RUNS, set overflow and go to WR_LO.
  - WR_LO: write run_count[7:0] to address 0.
  - WR_HI: write {4'b0, run_count[11:8]} to address 1.
  - DONE: done=1, busy=0. arm restarts via WAIT_QUIET.
- Memory write: one cycle per byte, with chipselect = clken = write = 1 together. Outside write cycles all three are 0, and address/writedata hold their last values. The port never reads.
- arm while busy is ignored.
- An edge in the same cycle as the QUIET threshold: the edge has priority, and the run is stored.
- Every run length is at least 0 units. Sub-unit runs store 0 and are still counted.

Decomposition:
- Shared package barcode_pkg:
  - state enum
  - HDR_LO_ADDR = 0, HDR_HI_ADDR = 1, RUN_BASE_ADDR = 2
  - RUN_LEN_MAX = 127
  - run-byte field positions
- One sub-module: barcode_sync_filter (synchronizer + FILTER glitch filter). It outputs the filtered level and a one-cycle edge strobe.

Test Plan:
Bench parameters throughout: PRESCALE=4, QUIET=8, FILTER=2.
- Reset/idle: hold reset 5 cycles, release, no arm -> all outputs 0, no mem_write for 200 cycles.
- Basic capture: arm; light 40 cycles; dark 12; light 20; dark 8; light 40 -> bytes 0x83 @2, 0x05 @3, 0x82 @4; then 0x03 @0, 0x00 @1; run_count=3; done=1.
- Glitch rejection: inside a dark run, a 1-cycle light pulse -> no extra run byte, dark length unaffected.
- Saturation: dark run of 600 cycles -> stored byte 0xFF.
- Overflow: MAX_RUNS=4, six short runs -> four run bytes, overflow=1, header 0x04/0x00, no write above address 5.
- Mid-capture reset and re-arm: assert reset during CAPTURE -> writes stop the next cycle, outputs 0. Arm during busy is ignored; arm after done starts a fresh capture with run_count cleared.
